ysyx_22050854_booth_seq_mul: RTL

YSYX_22050854_BOOTH_SEQ_MUL -- requirements
Module: ysyx_22050854_booth_seq_mul

---
 rtl/ysyx_22050854_mul_pkg.sv | 19 +
 rtl/ysyx_22050854_booth_sel.sv | 25 ++
 rtl/ysyx_22050854_booth_seq_mul.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ysyx_22050854_mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package ysyx_22050854_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_ITER   = 33;
  localparam int MULW_ITER  = 17;
  localparam int DATAPATH_W = 132;

  // mul_signed encodings; 2'b00 and 2'b01 are both unsigned*unsigned
  localparam logic [1:0] MS_SS = 2'b11;
  localparam logic [1:0] MS_SU = 2'b10;
  localparam logic [1:0] MS_UU = 2'b00;

endpackage

// File: rtl/ysyx_22050854_booth_sel.sv
// Radix-4 Booth digit decode: 3-bit window -> one-hot partial-product select.
module ysyx_22050854_booth_sel (
  input  logic [2:0] digit,
  output logic       sel_positive,
  output logic       sel_double_positive,
  output logic       sel_negative,
  output logic       sel_double_negative
);

  // Map the window {y[i+1], y[i], y[i-1]} to 0, +-x or +-2x
  always_comb begin
    sel_positive        = 1'b0;
    sel_double_positive = 1'b0;
    sel_negative        = 1'b0;
    sel_double_negative = 1'b0;
    case (digit)
      3'b001, 3'b010: sel_positive        = 1'b1;
      3'b011:         sel_double_positive = 1'b1;
      3'b100:         sel_double_negative = 1'b1;
      3'b101, 3'b110: sel_negative        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22050854_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier, one Booth digit per BUSY cycle.
//
// Handshake: a request is taken on a rising edge where mul_valid && mul_ready;
// mul_ready is high only in IDLE. A result is presented with out_valid held in
// DONE and is consumed on an edge where out_valid && out_ready. flush overrides
// both handshakes and returns the block to IDLE on the next edge.
module ysyx_22050854_booth_seq_mul
  import ysyx_22050854_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic        flush,
  input  logic        mulw,
  input  logic [1:0]  mul_signed,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result_hi,
  output logic [63:0] result_lo
);

  localparam logic [5:0] LAST_MUL  = 6'(MUL_ITER - 1);
  localparam logic [5:0] LAST_MULW = 6'(MULW_ITER - 1);

  mul_state_e state, state_nxt;

  logic [DATAPATH_W-1:0] acc, x_reg, x_ext, pp;
  logic [65:0]           y_reg, y_ext;
  logic [5:0]            cnt;
  logic                  mulw_q;
  logic                  accept, last_iter;
  logic                  x_sign, y_sign;
  logic                  sel_p, sel_2p, sel_n, sel_2n;

  assign accept    = (state == ST_IDLE) && mul_valid && !flush;
  assign last_iter = (cnt == (mulw_q ? LAST_MULW : LAST_MUL));

  // Operand extension: x to the full datapath, y to 65 bits plus a zero below bit 0
  always_comb begin
    x_sign = mul_signed[1] & (mulw ? multiplicand[31] : multiplicand[63]);
    y_sign = (mul_signed == MS_SS) & (mulw ? multiplier[31] : multiplier[63]);
    if (mulw) begin
      x_ext = {{100{x_sign}}, multiplicand[31:0]};
      y_ext = {{33{y_sign}}, multiplier[31:0], 1'b0};
    end else begin
      x_ext = {{68{x_sign}}, multiplicand};
      y_ext = {y_sign, multiplier, 1'b0};
    end
  end

  ysyx_22050854_booth_sel u_booth_sel (
    .digit               (y_reg[2:0]),
    .sel_positive        (sel_p),
    .sel_double_positive (sel_2p),
    .sel_negative        (sel_n),
    .sel_double_negative (sel_2n)
  );

  // Partial product; negative digits use one's complement with carry-in added in the accumulator
  always_comb begin
    pp = '0;
    if (sel_p)  pp = x_reg;
    if (sel_2p) pp = {x_reg[DATAPATH_W-2:0], 1'b0};
    if (sel_n)  pp = ~x_reg;
    if (sel_2n) pp = ~{x_reg[DATAPATH_W-2:0], 1'b0};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    mul_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        mul_ready = 1'b1;
        if (accept) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Datapath: latch operands on accept, one Booth step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      x_reg  <= '0;
      y_reg  <= '0;
      cnt    <= '0;
      mulw_q <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      x_reg  <= x_ext;
      y_reg  <= y_ext;
      cnt    <= '0;
      mulw_q <= mulw;
    end else if (state == ST_BUSY && !flush) begin
      acc    <= acc + pp + {{(DATAPATH_W-1){1'b0}}, (sel_n | sel_2n)};
      x_reg  <= {x_reg[DATAPATH_W-3:0], 2'b00};
      y_reg  <= {{2{y_reg[65]}}, y_reg[65:2]};
      cnt    <= cnt + 6'd1;
    end
  end

  // Results are visible only in DONE; mulw sign-extends the low word
  always_comb begin
    result_hi = '0;
    result_lo = '0;
    if (state == ST_DONE) begin
      if (mulw_q) begin
        result_lo = {{32{acc[31]}}, acc[31:0]};
      end else begin
        result_hi = acc[127:64];
        result_lo = acc[63:0];
      end
    end
  end

endmodule
